// File: rtl/synth_cmd_pkg.sv
// Shared constants, parser state encoding and decode helper for the MIDI-to-bank_manager
// command path.
package synth_cmd_pkg;

    localparam int CMD_W = 16;
    localparam logic [CMD_W-1:0] STOP_ALL_CMD = 16'h7F00;

    localparam logic [3:0] NOTE_OFF   = 4'h8;
    localparam logic [3:0] NOTE_ON    = 4'h9;
    localparam logic [3:0] POLY_AT    = 4'hA;
    localparam logic [3:0] CC         = 4'hB;
    localparam logic [3:0] PROG_CHG   = 4'hC;
    localparam logic [3:0] CHAN_AT    = 4'hD;
    localparam logic [3:0] PITCH_BEND = 4'hE;
    localparam logic [3:0] SYSTEM     = 4'hF;

    localparam logic [6:0] CC_ALL_SOUND_OFF = 7'd120;
    localparam logic [6:0] CC_ALL_NOTES_OFF = 7'd123;
    localparam logic [6:0] NOTE_RESERVED    = 7'd127;

    typedef enum logic [2:0] {
        IDLE, NOTE_D1, NOTE_D2, CC_D1, CC_D2, SKIP1, SKIP2, SYSEX
    } parser_state_t;

    // State entered right after a channel-message status byte.
    function automatic parser_state_t status_state(input logic [3:0] kind);
        parser_state_t st;
        case (kind)
            NOTE_OFF, NOTE_ON: st = NOTE_D1;
            CC:                st = CC_D1;
            PROG_CHG, CHAN_AT: st = SKIP1;
            default:           st = SKIP2;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Small power-of-2 command FIFO with flush; a write is accepted when full if a read
// happens on the same edge.
module cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    input  logic             flush,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_wr;
    logic             do_rd;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (flush || !full || do_rd);
    assign rd_data = mem[rd_ptr];

    // NOTE: storage has no reset; the pointers and count alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            // Everything already queued is discarded; only the concurrent write survives.
            rd_ptr <= wr_ptr;
            wr_ptr <= wr_ptr + AW'(do_wr);
            count  <= (AW+1)'(do_wr);
        end else begin
            wr_ptr <= wr_ptr + AW'(do_wr);
            rd_ptr <= rd_ptr + AW'(do_rd);
            count  <= count + (AW+1)'(do_wr) - (AW+1)'(do_rd);
        end
    end

endmodule

// File: rtl/midi_cmd_mediator.sv
// Parses a raw MIDI byte stream into one-cycle 16-bit bank_manager commands, buffered
// and spaced by a minimum number of idle cycles.
module midi_cmd_mediator
    import synth_cmd_pkg::*;
#(
    parameter int CHANNEL    = 0,
    parameter int OMNI       = 0,
    parameter int FIFO_DEPTH = 4,
    parameter int CMD_GAP    = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  i_byte,
    input  logic        i_byte_valid,
    output logic [15:0] o_data,
    output logic        o_overflow,
    output logic        o_pending
);

    localparam logic [3:0]    CHAN    = 4'(CHANNEL);
    localparam int            GW      = $clog2(CMD_GAP + 1);
    localparam logic [GW-1:0] GAP_MAX = GW'(CMD_GAP);

    parser_state_t    state, state_nxt;
    logic             rs_valid, rs_valid_nxt;
    logic [7:0]       rs_status, rs_status_nxt;
    logic [6:0]       data1, data1_nxt;
    logic             cmd_valid;
    logic             cmd_stop;
    logic [CMD_W-1:0] cmd_data;
    logic             chan_match;

    logic [CMD_W-1:0] fifo_rd_data;
    logic             fifo_full;
    logic             fifo_empty;
    logic [GW-1:0]    gap_cnt;
    logic             gap_ok;
    logic             pop;
    logic             drop;
    logic             drop_q;

    assign chan_match = (OMNI != 0) || (rs_status[3:0] == CHAN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            rs_valid  <= 1'b0;
            rs_status <= '0;
            data1     <= '0;
        end else begin
            state     <= state_nxt;
            rs_valid  <= rs_valid_nxt;
            rs_status <= rs_status_nxt;
            data1     <= data1_nxt;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path leaves one unassigned.
    always_comb begin
        state_nxt     = state;
        rs_valid_nxt  = rs_valid;
        rs_status_nxt = rs_status;
        data1_nxt     = data1;
        cmd_valid     = 1'b0;
        cmd_stop      = 1'b0;
        cmd_data      = '0;
        if (i_byte_valid) begin
            if (i_byte[7]) begin
                // Realtime bytes (F8..FF) leave the parser untouched.
                if (i_byte[7:3] != 5'b11111) begin
                    if (i_byte[7:4] == SYSTEM) begin
                        rs_valid_nxt = 1'b0;
                        case (i_byte[3:0])
                            4'h0:       state_nxt = SYSEX;
                            4'h1, 4'h3: state_nxt = SKIP1;
                            4'h2:       state_nxt = SKIP2;
                            default:    state_nxt = IDLE;
                        endcase
                    end else begin
                        rs_valid_nxt  = 1'b1;
                        rs_status_nxt = i_byte;
                        state_nxt     = status_state(i_byte[7:4]);
                    end
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (rs_valid) begin
                            case (status_state(rs_status[7:4]))
                                NOTE_D1: begin data1_nxt = i_byte[6:0]; state_nxt = NOTE_D2; end
                                CC_D1:   begin data1_nxt = i_byte[6:0]; state_nxt = CC_D2; end
                                SKIP2:   state_nxt = SKIP1;
                                default: state_nxt = IDLE;
                            endcase
                        end
                    end
                    NOTE_D1: begin data1_nxt = i_byte[6:0]; state_nxt = NOTE_D2; end
                    NOTE_D2: begin
                        state_nxt = IDLE;
                        if (chan_match && data1 != NOTE_RESERVED) begin
                            cmd_valid = 1'b1;
                            cmd_data  = {(rs_status[7:4] == NOTE_ON) && (i_byte[6:0] != 7'd0),
                                         data1, 1'b0, i_byte[6:0]};
                        end
                    end
                    CC_D1: begin data1_nxt = i_byte[6:0]; state_nxt = CC_D2; end
                    CC_D2: begin
                        state_nxt = IDLE;
                        if (chan_match && (data1 == CC_ALL_SOUND_OFF || data1 == CC_ALL_NOTES_OFF)) begin
                            cmd_valid = 1'b1;
                            cmd_stop  = 1'b1;
                            cmd_data  = STOP_ALL_CMD;
                        end
                    end
                    SKIP1:   state_nxt = IDLE;
                    SKIP2:   state_nxt = SKIP1;
                    SYSEX:   state_nxt = SYSEX;
                    default: state_nxt = IDLE;
                endcase
            end
        end
    end

    assign gap_ok    = (gap_cnt == GAP_MAX);
    assign pop       = !fifo_empty && gap_ok;
    assign drop      = cmd_valid && !cmd_stop && fifo_full && !pop;
    assign o_pending = !fifo_empty;

    cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (cmd_valid),
        .wr_data (cmd_data),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .flush   (cmd_stop),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // gap_cnt counts zero cycles since the last pop and saturates at CMD_GAP.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_data     <= '0;
            gap_cnt    <= GAP_MAX;
            drop_q     <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            o_data     <= pop ? fifo_rd_data : '0;
            drop_q     <= drop;
            o_overflow <= drop_q;
            if (pop)
                gap_cnt <= '0;
            else if (!gap_ok)
                gap_cnt <= gap_cnt + GW'(1);
        end
    end

endmodule

// File: tb/tb_midi_cmd_mediator.sv
// Directed byte sequences with a scoreboard of expected commands and their cycle of
// appearance; a negedge monitor pops and compares whenever o_data is non-zero.
module tb_midi_cmd_mediator;

    localparam int GAP = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  i_byte = 8'h00;
    logic        i_byte_valid = 1'b0;
    logic [15:0] o_data;
    logic        o_overflow;
    logic        o_pending;

    midi_cmd_mediator #(
        .CHANNEL    (0),
        .OMNI       (0),
        .FIFO_DEPTH (4),
        .CMD_GAP    (GAP)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .i_byte       (i_byte),
        .i_byte_valid (i_byte_valid),
        .o_data       (o_data),
        .o_overflow   (o_overflow),
        .o_pending    (o_pending)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] data;
        int          at;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] seq[$];
    int         checks = 0;
    int         errors = 0;
    int         ovf_count = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [15:0] mk_on(input logic [7:0] n, input logic [7:0] v);
        return {1'b1, n[6:0], 1'b0, v[6:0]};
    endfunction

    task automatic expect_cmd(input logic [15:0] d, input int at);
        exp_t e;
        e.data = d;
        e.at   = at;
        exp_q.push_back(e);
    endtask

    task automatic send(input logic [7:0] b);
        i_byte       = b;
        i_byte_valid = 1'b1;
        @(negedge clk);
        i_byte_valid = 1'b0;
        i_byte       = 8'h00;
    endtask

    task automatic send_all();
        foreach (seq[i]) send(seq[i]);
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        settle(8);
        check(name, exp_q.size(), 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (o_overflow) ovf_count++;
            if (o_data != 16'h0000) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_cmd", {16'h0000, o_data}, 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    check("cmd_data", {16'h0000, o_data}, {16'h0000, e.data});
                    check("cmd_cycle", cyc, e.at);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int s;
        int pos;

        settle(3);
        check("rst_data", {16'h0000, o_data}, 32'h0);
        check("rst_overflow", {31'h0, o_overflow}, 32'h0);
        check("rst_pending", {31'h0, o_pending}, 32'h0);
        reset = 1'b0;
        settle(2);

        // Basic note-on, two edges after the last byte.
        s = cyc;
        expect_cmd(16'hC564, s + 4);
        seq = '{8'h90, 8'h45, 8'h64};
        send_all();
        drain("drain_basic");

        // Running status: second command waits out the gap.
        s = cyc;
        expect_cmd(16'hC564, s + 4);
        expect_cmd(16'hA840, s + 9);
        seq = '{8'h90, 8'h45, 8'h64, 8'h28, 8'h40};
        send_all();
        drain("drain_running");

        // Note-on with zero velocity and note-off both map to on=0.
        s = cyc;
        expect_cmd(16'h4500, s + 4);
        expect_cmd(16'h457F, s + 9);
        seq = '{8'h90, 8'h45, 8'h00, 8'h80, 8'h45, 8'h7F};
        send_all();
        drain("drain_off");

        seq = '{8'h90, 8'h7F, 8'h40};
        send_all();
        drain("drain_note127");

        // Realtime bytes interleaved are transparent.
        s = cyc;
        expect_cmd(16'hC564, s + 6);
        seq = '{8'h90, 8'hF8, 8'h45, 8'hF8, 8'h64};
        send_all();
        drain("drain_realtime");

        // Abort by a new status, then wrong channel; other CCs and sysex emit nothing.
        seq = '{8'h90, 8'h45, 8'h91, 8'h3C, 8'h40};
        send_all();
        drain("drain_abort_chan");
        seq = '{8'hB0, 8'h07, 8'h64, 8'hF0, 8'h45, 8'h64, 8'hF7, 8'h45, 8'h64};
        send_all();
        drain("drain_cc_sysex");

        // Burst of 10 running-status notes: pops every GAP+1 cycles, two overflow drops.
        s = cyc;
        pos = 0;
        for (int i = 0; i < 10; i++) begin
            if (i != 7 && i != 9) begin
                expect_cmd(mk_on(8'(8'h30 + i), 8'(8'h10 + i)), s + 4 + 5 * pos);
                pos++;
            end
        end
        seq = '{8'h90};
        for (int i = 0; i < 10; i++) begin
            seq.push_back(8'(8'h30 + i));
            seq.push_back(8'(8'h10 + i));
        end
        send_all();
        check("burst_pending", {31'h0, o_pending}, 32'h1);
        drain("drain_burst");
        check("burst_overflows", ovf_count, 2);

        // STOP_ALL flushes the two notes still queued and keeps the gap.
        s = cyc;
        expect_cmd(mk_on(8'h50, 8'h10), s + 4);
        expect_cmd(mk_on(8'h51, 8'h11), s + 9);
        expect_cmd(16'h7F00, s + 14);
        seq = '{8'h90, 8'h50, 8'h10, 8'h51, 8'h11, 8'h52, 8'h12, 8'h53, 8'h13,
                8'hB0, 8'h7B, 8'h00};
        send_all();
        drain("drain_stop123");

        s = cyc;
        expect_cmd(16'h7F00, s + 4);
        seq = '{8'hB0, 8'h78, 8'h05};
        send_all();
        drain("drain_stop120");

        // Asynchronous reset clears a command already on o_data.
        seq = '{8'h90, 8'h45, 8'h64};
        send_all();
        @(posedge clk);
        #1;
        check("pre_reset_data", {16'h0000, o_data}, 32'h0000C564);
        reset = 1'b1;
        #1;
        check("async_reset_data", {16'h0000, o_data}, 32'h0);
        check("async_reset_pending", {31'h0, o_pending}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        settle(2);

        // Reset mid-message discards the partial note and running status.
        seq = '{8'h90, 8'h45};
        send_all();
        #2 reset = 1'b1;
        #2 reset = 1'b0;
        @(negedge clk);
        seq = '{8'h64, 8'h28, 8'h40};
        send_all();
        drain("drain_reset_midmsg");
        check("final_pending", {31'h0, o_pending}, 32'h0);
        check("final_overflows", ovf_count, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
